// File: rtl/spi_slave_filtered_if.sv
// Purpose: bundles the SPI pins and the core-side register port of
//          spi_slave_filtered into one connection.
// Signals:
//   spi_clk, spi_cs, spi_mosi : raw SPI inputs from the Pi (CS active-low)
//   spi_miso, spi_miso_oe     : MISO data and its output enable
//   data_we, data_addr,
//   data_write, data_read     : core write strobe, byte address, write/read data
//   frame_done                : one-cycle pulse after a complete 40-bit frame
// Modports: master = the side driving the link (Pi + core), slave = the block.
interface spi_slave_filtered_if;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        frame_done;

    modport master (
        output spi_clk, spi_cs, spi_mosi,
        output data_we, data_addr, data_write,
        input  spi_miso, spi_miso_oe, data_read, frame_done
    );

    modport slave (
        input  spi_clk, spi_cs, spi_mosi,
        input  data_we, data_addr, data_write,
        output spi_miso, spi_miso_oe, data_read, frame_done
    );
endinterface

// File: rtl/spi_slave_filtered.sv
// Purpose: SPI mode-0 slave (MSB first, 40-bit frames: 8-bit header + 32-bit
//          data) in front of a 2^ADDR_BITS x 32-bit register bank shared with
//          the FPGA core. Every raw SPI input goes through a 2-FF synchronizer
//          and a stability filter before use.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : spi_slave_filtered_if.slave (SPI pins + core register port)
module spi_slave_filtered #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned ADDR_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_slave_filtered_if.slave  bus
);

    localparam int unsigned WORDS      = 1 << ADDR_BITS;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned HDR_BITS   = 8;
    localparam int unsigned FRAME_BITS = HDR_BITS + DATA_W;
    localparam int unsigned BCNT_W     = 6;
    localparam int unsigned FCNT_W     = 4;
    localparam int unsigned N_IN       = 3;
    localparam int unsigned IN_SCLK    = 0;
    localparam int unsigned IN_CS      = 1;
    localparam int unsigned IN_MOSI    = 2;
    // Idle levels: CS deasserted (1), SCLK and MOSI low.
    localparam logic [N_IN-1:0] IN_IDLE = 3'b010;

    // ------------------------------------------------------------------
    // Input conditioning: synchronizer + stability filter per input
    // ------------------------------------------------------------------
    logic [N_IN-1:0]   raw_in;
    logic [N_IN-1:0]   sync1;
    logic [N_IN-1:0]   sync2;
    logic [N_IN-1:0]   filt;
    logic [N_IN-1:0]   filt_nxt;
    logic [FCNT_W-1:0] fcnt     [N_IN];
    logic [FCNT_W-1:0] fcnt_nxt [N_IN];
    logic              sclk_prev;
    logic              miso_oe_q;

    assign raw_in = {bus.spi_mosi, bus.spi_cs, bus.spi_clk};

    // Filter: count consecutive samples that disagree with the filtered value;
    // the FILTER_LEN-th such sample commits the new level.
    always_comb begin
        filt_nxt = filt;
        for (int i = 0; i < N_IN; i++) begin
            fcnt_nxt[i] = '0;
            if (sync2[i] != filt[i]) begin
                if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                    filt_nxt[i] = sync2[i];
                end else begin
                    fcnt_nxt[i] = fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    // Conditioning registers; synchronizers reset to the idle levels so no
    // spurious transition is filtered in after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= IN_IDLE;
            sync2     <= IN_IDLE;
            filt      <= IN_IDLE;
            sclk_prev <= 1'b0;
            miso_oe_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            filt      <= filt_nxt;
            sclk_prev <= filt[IN_SCLK];
            miso_oe_q <= ~filt_nxt[IN_CS];
            for (int i = 0; i < N_IN; i++) begin
                fcnt[i] <= fcnt_nxt[i];
            end
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_f;
    logic mosi_f;

    assign sclk_rise = filt[IN_SCLK] & ~sclk_prev;
    assign sclk_fall = ~filt[IN_SCLK] & sclk_prev;
    assign cs_n_f    = filt[IN_CS];
    assign mosi_f    = filt[IN_MOSI];

    // ------------------------------------------------------------------
    // Frame engine
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    bank [WORDS];
    logic [BCNT_W-1:0]    bit_cnt;
    logic [DATA_W-2:0]    rx_sr;
    logic [DATA_W-1:0]    tx_sr;
    logic                 is_write;
    logic [ADDR_BITS-1:0] spi_addr;
    logic                 frame_done_q;
    logic [HDR_BITS-1:0]  hdr_c;
    logic [DATA_W-1:0]    rx_word_c;
    logic                 bit_take_c;
    logic                 spi_we_c;

    // Header and data word as they stand once the current MOSI bit is taken.
    assign hdr_c      = {rx_sr[HDR_BITS-2:0], mosi_f};
    assign rx_word_c  = {rx_sr, mosi_f};
    assign bit_take_c = sclk_rise & ~cs_n_f & (bit_cnt < BCNT_W'(FRAME_BITS));
    assign spi_we_c   = bit_take_c & is_write & (bit_cnt == BCNT_W'(FRAME_BITS - 1));

    // Bit counter, shift registers and header decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            is_write     <= 1'b0;
            spi_addr     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (cs_n_f) begin
                bit_cnt  <= '0;
                rx_sr    <= '0;
                tx_sr    <= '0;
                is_write <= 1'b0;
            end else if (bit_take_c) begin
                bit_cnt <= bit_cnt + BCNT_W'(1);
                rx_sr   <= rx_word_c[DATA_W-2:0];
                if (bit_cnt == BCNT_W'(HDR_BITS - 1)) begin
                    is_write <= hdr_c[HDR_BITS-1];
                    spi_addr <= hdr_c[ADDR_BITS-1:0];
                    // Read snapshot: MISO shows its MSB straight away.
                    if (!hdr_c[HDR_BITS-1]) begin
                        tx_sr <= bank[hdr_c[ADDR_BITS-1:0]];
                    end
                end
                if (bit_cnt == BCNT_W'(FRAME_BITS - 1)) begin
                    frame_done_q <= 1'b1;
                end
            end else if (sclk_fall && (bit_cnt > BCNT_W'(HDR_BITS))
                         && (bit_cnt < BCNT_W'(FRAME_BITS))) begin
                // No shift on the fall right after the load: the Pi has not
                // yet sampled data bit 31.
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank and core read port
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] core_word;
    logic [DATA_W-1:0]    data_read_q;

    assign core_word = bus.data_addr[ADDR_BITS+1:2];

    // SPI write is applied after the core write so it wins a same-word collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                bank[i] <= '0;
            end
            data_read_q <= '0;
        end else begin
            if (bus.data_we) begin
                bank[core_word] <= bus.data_write;
            end
            if (spi_we_c) begin
                bank[spi_addr] <= rx_word_c;
            end
            data_read_q <= bank[core_word];
        end
    end

    // Address bits outside the word select and unused header bits.
    logic unused_bits;
    assign unused_bits = ^{bus.data_addr[31:ADDR_BITS+2], bus.data_addr[1:0],
                           hdr_c[HDR_BITS-2:ADDR_BITS]};

    assign bus.spi_miso    = tx_sr[DATA_W-1];
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.data_read   = data_read_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_slave_filtered.sv
// Purpose: directed self-checking bench for spi_slave_filtered: reset,
//          core<->SPI transfers, glitch rejection, abort, collision and read
//          snapshot, with hand-computed expected values.
module tb_spi_slave_filtered;

    localparam int unsigned HALF = 10;   // SCLK half-period in clk cycles

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;

    spi_slave_filtered_if bus ();

    spi_slave_filtered #(
        .FILTER_LEN (4),
        .ADDR_BITS  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bus.frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.data_addr  = addr;
        bus.data_write = data;
        bus.data_we    = 1'b1;
        tick(1);
        bus.data_we    = 1'b0;
    endtask

    task automatic core_read(input logic [31:0] addr, output logic [31:0] data);
        bus.data_addr = addr;
        tick(2);
        data = bus.data_read;
    endtask

    // mode 0: clean frame, 1: SCLK/MOSI glitches, 2: core write aligned with
    // the 40th filtered rising edge. rd collects MISO at raw rises 9..40.
    task automatic spi_frame(input logic [7:0] hdr, input logic [31:0] data,
                             input int nbits, input int mode,
                             input logic [31:0] c_addr, input logic [31:0] c_data,
                             output logic [31:0] rd);
        logic [39:0] frame;
        frame = {hdr, data};
        rd = '0;
        bus.spi_cs = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = frame[39-i];
            if (mode == 1 && i == 15) begin
                tick(2);
                bus.spi_mosi = ~frame[39-i];
                tick(3);
                bus.spi_mosi = frame[39-i];
                tick(HALF - 5);
            end else begin
                tick(HALF);
            end
            bus.spi_clk = 1'b1;
            if (i >= 8) rd = {rd[30:0], bus.spi_miso};
            if (mode == 2 && i == 39) begin
                tick(6);
                bus.data_addr  = c_addr;
                bus.data_write = c_data;
                bus.data_we    = 1'b1;
                tick(1);
                bus.data_we    = 1'b0;
                tick(HALF - 7);
            end else if (mode == 1 && i == 20) begin
                tick(5);
                bus.spi_clk = 1'b0;
                tick(2);
                bus.spi_clk = 1'b1;
                tick(HALF);
            end else begin
                tick(HALF);
            end
            bus.spi_clk = 1'b0;
        end
        tick(HALF);
        bus.spi_cs = 1'b1;
        tick(HALF + 8);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] val;
        int          d0;

        bus.spi_clk    = 1'b0;
        bus.spi_cs     = 1'b1;
        bus.spi_mosi   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_write = '0;

        // Reset state
        tick(3);
        check("rst_miso",  32'(bus.spi_miso),    32'd0);
        check("rst_oe",    32'(bus.spi_miso_oe), 32'd0);
        check("rst_done",  32'(bus.frame_done),  32'd0);
        check("rst_rdata", bus.data_read,        32'd0);
        reset = 1'b1;
        tick(2);

        // Reset asserted in mid-frame clears word 3 and all outputs
        core_write(32'h0C, 32'h1234_5678);
        core_read(32'h0C, val);
        check("w3_pre", val, 32'h1234_5678);
        bus.spi_cs = 1'b0;
        tick(HALF);
        for (int i = 0; i < 5; i++) begin
            bus.spi_mosi = 1'b0;
            tick(HALF);
            bus.spi_clk = 1'b1;
            tick(HALF);
            bus.spi_clk = 1'b0;
        end
        check("mid_oe", 32'(bus.spi_miso_oe), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_miso",  32'(bus.spi_miso),    32'd0);
        check("mid_rst_oe",    32'(bus.spi_miso_oe), 32'd0);
        check("mid_rst_done",  32'(bus.frame_done),  32'd0);
        check("mid_rst_rdata", bus.data_read,        32'd0);
        bus.spi_cs = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        core_read(32'h0C, val);
        check("w3_post_rst", val, 32'd0);

        // Core write with one-cycle read latency, then SPI read of word 2
        core_write(32'h08, 32'hDEAD_BEEF);
        check("rd_lat0", bus.data_read, 32'd0);
        tick(1);
        check("rd_lat1", bus.data_read, 32'hDEAD_BEEF);
        d0 = done_cnt;
        spi_frame(8'h02, 32'h0, 40, 0, 32'h0, 32'h0, rd);
        check("spi_rd_w2", rd, 32'hDEAD_BEEF);
        check("spi_rd_done", 32'(done_cnt - d0), 32'd1);
        check("idle_oe", 32'(bus.spi_miso_oe), 32'd0);

        // SPI write of word 5, core read via byte address 0x14
        d0 = done_cnt;
        spi_frame(8'h85, 32'h0000_0005, 40, 0, 32'h0, 32'h0, rd);
        check("spi_wr_miso", rd, 32'd0);
        check("spi_wr_done", 32'(done_cnt - d0), 32'd1);
        core_read(32'h14, val);
        check("core_rd_w5", val, 32'h0000_0005);

        // Glitch rejection on SCLK and MOSI
        d0 = done_cnt;
        spi_frame(8'h86, 32'hA5A5_5A5A, 40, 1, 32'h0, 32'h0, rd);
        core_read(32'h18, val);
        check("glitch_w6", val, 32'hA5A5_5A5A);
        check("glitch_done", 32'(done_cnt - d0), 32'd1);

        // Abort after 20 bits of a write to word 1
        core_write(32'h04, 32'hCAFE_F00D);
        d0 = done_cnt;
        spi_frame(8'h81, 32'h0BAD_0BAD, 20, 0, 32'h0, 32'h0, rd);
        core_read(32'h04, val);
        check("abort_w1", val, 32'hCAFE_F00D);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        spi_frame(8'h01, 32'h0, 40, 0, 32'h0, 32'h0, rd);
        check("post_abort_rd", rd, 32'hCAFE_F00D);
        spi_frame(8'h81, 32'h1357_9BDF, 40, 0, 32'h0, 32'h0, rd);
        core_read(32'h04, val);
        check("post_abort_wr", val, 32'h1357_9BDF);
        check("post_abort_done", 32'(done_cnt - d0), 32'd2);

        // Collision on the same word: SPI wins
        spi_frame(8'h84, 32'h2222_2222, 40, 2, 32'h10, 32'h1111_1111, rd);
        core_read(32'h10, val);
        check("coll_same_w4", val, 32'h2222_2222);

        // Collision on different words: both land
        spi_frame(8'h87, 32'h7777_7777, 40, 2, 32'h20, 32'h8888_8888, rd);
        core_read(32'h1C, val);
        check("coll_diff_w7", val, 32'h7777_7777);
        core_read(32'h20, val);
        check("coll_diff_w8", val, 32'h8888_8888);

        // Read snapshot: a core write mid-frame does not disturb the shift-out
        fork
            spi_frame(8'h02, 32'h0, 40, 0, 32'h0, 32'h0, rd);
            begin
                tick(2 * HALF * 20);
                core_write(32'h08, 32'h0000_0000);
            end
        join
        check("snapshot_rd", rd, 32'hDEAD_BEEF);
        core_read(32'h08, val);
        check("snapshot_w2", val, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
